// File: rtl/mem_req_arbiter.sv
// ============================================================================
//  Module   : mem_req_arbiter
//  Purpose  : Round-robin front-end that keeps one memory transaction in
//             flight and routes its completion back to the requesting core.
//  Option   : MEM_ARB_TIMEOUT_EN adds a WAIT watchdog with error completion.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter #(
   parameter int NUM_PROCESSORS = 4,
   parameter int ADDR_W         = 14,
   parameter int DATA_SIZE      = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_PROCESSORS-1:0]             proc_req_valid,
   input  logic [NUM_PROCESSORS-1:0]             proc_req_we,
   input  logic [NUM_PROCESSORS*ADDR_W-1:0]      proc_req_addr,
   input  logic [NUM_PROCESSORS*DATA_SIZE*8-1:0] proc_req_wdata,
   output logic [NUM_PROCESSORS-1:0]             proc_req_ready,
   output logic [NUM_PROCESSORS-1:0]             proc_resp_valid,
   output logic [DATA_SIZE*8-1:0]                proc_resp_data,
   output logic                                  proc_resp_err,
   output logic                                  mem_read_req,
   output logic                                  mem_write_req,
   output logic [ADDR_W-1:0]                     addr,
   output logic [DATA_SIZE*8-1:0]                mem_write_data,
   input  logic                                  mem_resp_valid,
   input  logic [DATA_SIZE*8-1:0]                mem_read_data,
   output logic                                  busy,
   output logic                                  spurious_resp
);

   localparam int DW    = DATA_SIZE * 8;
   localparam int PTR_W = $clog2(NUM_PROCESSORS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]    owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DW-1:0]       wdata_q, wdata_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic                spurious_q, spurious_d;

   logic                w_grant_found;
   logic [PTR_W-1:0]    w_grant_idx;
   logic [PTR_W-1:0]    w_scan;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
`endif

   // First valid requester at or after rr_ptr, wrapping modulo N.
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_scan        = '0;
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
         w_scan = PTR_W'((int'(rr_ptr_q) + i) % NUM_PROCESSORS);
         if (!w_grant_found && proc_req_valid[w_scan]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = w_scan;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      spurious_d = spurious_q | (mem_resp_valid && (state_q != S_WAIT));
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (w_grant_found) begin
               owner_d  = w_grant_idx;
               we_d     = proc_req_we[w_grant_idx];
               addr_d   = proc_req_addr[w_grant_idx*ADDR_W +: ADDR_W];
               wdata_d  = proc_req_wdata[w_grant_idx*DW +: DW];
               rr_ptr_d = (w_grant_idx == PTR_W'(NUM_PROCESSORS - 1)) ? '0 : w_grant_idx + 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A completion on the expiry cycle takes priority over the timeout.
            if (mem_resp_valid) begin
               rdata_d = we_q ? '0 : mem_read_data;
               state_d = S_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
               err_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         spurious_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         spurious_q <= spurious_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   always_comb begin
      proc_req_ready  = '0;
      proc_resp_valid = '0;
      proc_resp_data  = '0;
      proc_resp_err   = 1'b0;
      if (state_q == S_IDLE && w_grant_found) begin
         proc_req_ready[w_grant_idx] = 1'b1;
      end
      if (state_q == S_RESP) begin
         proc_resp_valid[owner_q] = 1'b1;
         proc_resp_data           = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
         proc_resp_err            = err_q;
`endif
      end
   end

   assign mem_read_req   = (state_q == S_ISSUE) && !we_q;
   assign mem_write_req  = (state_q == S_ISSUE) && we_q;
   assign addr           = addr_q;
   assign mem_write_data = wdata_q;
   assign busy           = (state_q != S_IDLE);
   assign spurious_resp  = spurious_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// ============================================================================
//  Module   : tb_mem_req_arbiter
//  Purpose  : Scoreboard bench for mem_req_arbiter with a memory model and a
//             round-robin reference; honours MEM_ARB_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_req_arbiter;

   localparam int NP = 4;
   localparam int AW = 14;
   localparam int DW = 16;
   localparam int TO = 64;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct {
      int            owner;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            acc_cyc;
   } exp_t;

   typedef struct {
      logic [NP-1:0] vec;
      logic [DW-1:0] data;
      logic          err;
   } rsp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [NP-1:0]    proc_req_valid, proc_req_we, proc_req_ready, proc_resp_valid;
   logic [NP*AW-1:0] proc_req_addr;
   logic [NP*DW-1:0] proc_req_wdata;
   logic [DW-1:0]    proc_resp_data, mem_write_data, mem_read_data;
   logic             proc_resp_err, mem_read_req, mem_write_req, mem_resp_valid, busy, spurious_resp;
   logic [AW-1:0]    addr;

   mem_req_arbiter #(
      .NUM_PROCESSORS (NP),
      .ADDR_W         (AW),
      .DATA_SIZE      (DW/8),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .proc_req_valid  (proc_req_valid),
      .proc_req_we     (proc_req_we),
      .proc_req_addr   (proc_req_addr),
      .proc_req_wdata  (proc_req_wdata),
      .proc_req_ready  (proc_req_ready),
      .proc_resp_valid (proc_resp_valid),
      .proc_resp_data  (proc_resp_data),
      .proc_resp_err   (proc_resp_err),
      .mem_read_req    (mem_read_req),
      .mem_write_req   (mem_write_req),
      .addr            (addr),
      .mem_write_data  (mem_write_data),
      .mem_resp_valid  (mem_resp_valid),
      .mem_read_data   (mem_read_data),
      .busy            (busy),
      .spurious_resp   (spurious_resp)
   );

   int      n_tests = 0;
   int      n_fail  = 0;
   int      cyc     = 0;
   req_t    cq [NP][$];
   exp_t    sb [$];
   rsp_t    resp_log [$];
   int      grant_log [$];
   int      gcyc_log [$];
   logic [DW-1:0] mem_arr [0:(1<<AW)-1];

   logic [NP-1:0] acc_mask = '0;
   int      m_rr = 0;
   bit      m_busy = 1'b0;
   int      p_g;
   logic [NP-1:0] p_er;
   exp_t    p_e;

   int      c_due = -1;
   bit      c_ok  = 1'b1;
   bit      c_err = 1'b0;
   exp_t    c_e;
   rsp_t    c_r;

   bit      mem_mute = 1'b0;
   int      mem_fixed_delay = 0;
   bit      spur_req = 1'b0;
   int      mcd = -1;
   logic [DW-1:0] mdat = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference arbiter: predicts the grant and pushes the expected completion.
   always @(negedge clk) begin
      acc_mask = '0;
      if (reset) begin
         sb.delete();
         m_rr   = 0;
         m_busy = 1'b0;
      end else begin
         p_g = -1;
         if (!m_busy)
            for (int k = 0; k < NP; k++)
               if (p_g < 0 && proc_req_valid[(m_rr + k) % NP]) p_g = (m_rr + k) % NP;
         p_er = (p_g >= 0) ? (NP'(1) << p_g) : '0;
         if (p_er != 0 || proc_req_ready != 0) chk("grant", proc_req_ready, p_er);
         if (p_g >= 0 && proc_req_ready == p_er) begin
            p_e.owner   = p_g;
            p_e.we      = proc_req_we[p_g];
            p_e.addr    = proc_req_addr[p_g*AW +: AW];
            p_e.wdata   = proc_req_wdata[p_g*DW +: DW];
            p_e.rdata   = p_e.we ? '0 : mem_arr[p_e.addr];
            p_e.acc_cyc = cyc;
            sb.push_back(p_e);
            grant_log.push_back(p_g);
            gcyc_log.push_back(cyc);
            acc_mask = p_er;
            m_rr     = (p_g + 1) % NP;
            m_busy   = 1'b1;
         end
         if (proc_resp_valid != 0) m_busy = 1'b0;
      end
   end

   // Monitor: checks issue pulses, timing, and pops completions.
   always @(negedge clk) begin
      if (reset) begin
         c_due = -1;
         c_ok  = 1'b1;
         c_err = 1'b0;
      end else begin
         if (mem_read_req && mem_write_req) chk("req_exclusive", 2'b11, 2'b01);
         if (sb.size() > 0) begin
            if (cyc == sb[0].acc_cyc + 1) begin
               chk("issue_kind", {mem_write_req, mem_read_req}, sb[0].we ? 2'b10 : 2'b01);
               chk("issue_addr", addr, sb[0].addr);
               if (sb[0].we) chk("issue_wdata", mem_write_data, sb[0].wdata);
               c_due = -1;
               c_ok  = 1'b1;
            end else if (mem_read_req || mem_write_req) begin
               chk("issue_extra", {mem_write_req, mem_read_req}, 2'b00);
            end
            if (cyc >= sb[0].acc_cyc + 2 && c_due < 0) begin
               if (addr !== sb[0].addr) c_ok = 1'b0;
               if (mem_resp_valid) begin
                  c_due = cyc + 1;
                  c_err = 1'b0;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (cyc == sb[0].acc_cyc + 2 + TO) begin
                  c_due = cyc + 1;
                  c_err = 1'b1;
               end
`endif
            end
         end else if (mem_read_req || mem_write_req) begin
            chk("issue_extra", {mem_write_req, mem_read_req}, 2'b00);
         end
         if (proc_resp_valid != 0) begin
            if (sb.size() == 0) begin
               chk("resp_unexpected", proc_resp_valid, 0);
            end else begin
               c_e = sb.pop_front();
               chk("resp_cycle", cyc, c_due);
               chk("resp_owner", proc_resp_valid, NP'(1) << c_e.owner);
               chk("resp_data", proc_resp_data, c_err ? '0 : c_e.rdata);
               chk("resp_err", proc_resp_err, c_err);
               chk("addr_stable", c_ok, 1);
               c_r.vec  = proc_resp_valid;
               c_r.data = proc_resp_data;
               c_r.err  = proc_resp_err;
               resp_log.push_back(c_r);
               c_due = -1;
               c_ok  = 1'b1;
            end
         end else if (sb.size() > 0 && c_due >= 0 && cyc == c_due) begin
            chk("resp_missing", 0, 1);
         end
      end
   end

   // Memory model: answers each issue after a programmable or random delay.
   initial begin
      mem_resp_valid = 1'b0;
      mem_read_data  = '0;
      for (int i = 0; i < (1 << AW); i++) mem_arr[i] = DW'(i * 37 + 5);
      mem_arr[14'h0040] = 16'hBEEF;
      forever begin
         @(negedge clk);
         if (reset) begin
            mcd = -1;
         end else if ((mem_read_req || mem_write_req) && !mem_mute) begin
            mcd = (mem_fixed_delay > 0) ? mem_fixed_delay : int'($urandom_range(1, 12));
            if (mem_write_req) begin
               mem_arr[addr] = mem_write_data;
               mdat = DW'($urandom);
            end else begin
               mdat = mem_arr[addr];
            end
         end
         @(posedge clk);
         #1;
         mem_resp_valid = spur_req;
         if (mcd > 0) begin
            mcd--;
            if (mcd == 0) begin
               mem_resp_valid = 1'b1;
               mem_read_data  = mdat;
               mcd = -1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
         if (acc_mask[i] && cq[i].size() > 0) void'(cq[i].pop_front());
         proc_req_valid[i] = (cq[i].size() > 0);
         if (cq[i].size() > 0) begin
            proc_req_we[i]              = cq[i][0].we;
            proc_req_addr[i*AW +: AW]   = cq[i][0].addr;
            proc_req_wdata[i*DW +: DW]  = cq[i][0].wdata;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   function automatic bit pending();
      bit p;
      p = m_busy || busy || (sb.size() > 0);
      for (int i = 0; i < NP; i++) if (cq[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      tick();
      while (pending() && n < 3000) begin
         tick();
         n++;
      end
      if (pending()) chk({nm, "_drain"}, 0, 1);
   endtask

   task automatic push(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d;
      cq[c].push_back(r);
   endtask

   initial begin
      int base, n, c;
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n, c;
      proc_req_valid = '0; proc_req_we = '0; proc_req_addr = '0; proc_req_wdata = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("reset_outputs", {proc_req_ready, proc_resp_valid, proc_resp_data, proc_resp_err,
                            mem_read_req, mem_write_req, addr, mem_write_data, busy, spurious_resp}, 0);

      // Single read with a 10-cycle memory latency
      mem_fixed_delay = 10;
      base = resp_log.size();
      push(2, 1'b0, 14'h0040, 16'h0);
      wait_idle("t1");
      if (resp_log.size() > base) begin
         chk("t1_vec", resp_log[base].vec, 4'b0100);
         chk("t1_data", resp_log[base].data, 16'hBEEF);
         chk("t1_err", resp_log[base].err, 0);
      end else chk("t1_resp", 0, 1);
      mem_fixed_delay = 0;

      // All cores valid from reset
      reset = 1'b1;
      for (int i = 0; i < NP; i++) begin
         push(i, 1'b0, AW'(i), '0);
         push(i, 1'b1, AW'(i + 8), DW'(i * 3));
      end
      base = grant_log.size();
      tick(); tick();
      reset = 1'b0;
      wait_idle("t2");
      if (grant_log.size() >= base + 5) begin
         chk("rr_0", grant_log[base], 0);
         chk("rr_1", grant_log[base+1], 1);
         chk("rr_2", grant_log[base+2], 2);
         chk("rr_3", grant_log[base+3], 3);
         chk("rr_4", grant_log[base+4], 0);
      end else chk("rr_count", grant_log.size() - base, 5);

      // rr_ptr at 2 with only P0/P1 requesting
      do_reset();
      push(1, 1'b0, 14'h0011, '0);
      wait_idle("t3a");
      base = grant_log.size();
      push(0, 1'b1, 14'h0022, 16'h5A5A);
      push(1, 1'b0, 14'h0022, '0);
      wait_idle("t3b");
      if (grant_log.size() >= base + 2) begin
         chk("rr_wrap_0", grant_log[base], 0);
         chk("rr_wrap_1", grant_log[base+1], 1);
      end else chk("rr_wrap_count", grant_log.size() - base, 2);

      // Write at top of the address space
      base = resp_log.size();
      push(1, 1'b1, 14'h3FFF, 16'h1234);
      wait_idle("t4");
      if (resp_log.size() > base) begin
         chk("t4_vec", resp_log[base].vec, 4'b0010);
         chk("t4_data", resp_log[base].data, 0);
      end else chk("t4_resp", 0, 1);

      // Reset three cycles after issue drops the transaction
      mem_mute = 1'b1;
      push(0, 1'b0, 14'h0100, '0);
      n = 0;
      while (!mem_read_req && n < 20) begin tick(); n++; end
      chk("t5_issue", mem_read_req, 1);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_no_resp", proc_resp_valid, 0);
      chk("t5_spur_clear", spurious_resp, 0);
      mem_mute = 1'b0;
      spur_req = 1'b1;
      tick(); tick();
      spur_req = 1'b0;
      tick();
      chk("t5_spurious", spurious_resp, 1);
      do_reset();
      chk("t5_spur_reset", spurious_resp, 0);

      // Memory never answers
      mem_mute = 1'b1;
      push(1, 1'b0, 14'h0200, '0);
`ifdef MEM_ARB_TIMEOUT_EN
      base = resp_log.size();
      wait_idle("t6");
      if (resp_log.size() > base) begin
         chk("t6_vec", resp_log[base].vec, 4'b0010);
         chk("t6_err", resp_log[base].err, 1);
         chk("t6_data", resp_log[base].data, 0);
      end else chk("t6_resp", 0, 1);
      mem_mute = 1'b0;
`else
      repeat (200) tick();
      chk("t6_still_busy", busy, 1);
      mem_mute = 1'b0;
      do_reset();
`endif

      // Back-to-back from one core at minimum memory latency
      mem_fixed_delay = 1;
      base = grant_log.size();
      push(3, 1'b0, 14'h0333, '0);
      push(3, 1'b1, 14'h0333, 16'hC0DE);
      wait_idle("t7");
      if (grant_log.size() >= base + 2) begin
         chk("b2b_owner", grant_log[base+1], 3);
         chk("b2b_spacing", gcyc_log[base+1] - gcyc_log[base], 4);
      end else chk("b2b_count", grant_log.size() - base, 2);
      mem_fixed_delay = 0;

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            c = int'($urandom_range(0, NP - 1));
            if (cq[c].size() < 3)
               push(c, 1'(($urandom_range(0, 1))),
                    ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom),
                    DW'($urandom));
         end
         tick();
      end
      wait_idle("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
